// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: state enum, opcode/funct
// values and the datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_JR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] ALUB_REG   = 2'd0;
    localparam logic [1:0] ALUB_FOUR  = 2'd1;
    localparam logic [1:0] ALUB_IMM   = 2'd2;
    localparam logic [1:0] ALUB_IMMSH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_IMM   = 2'd3;

endpackage

// File: rtl/mips_op_decode.sv
// Opcode/funct to post-DECODE state map; purely combinational, zero latency.
// No backpressure: output follows the instruction register fields directly.
module mips_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output state_t              o_next_state,
    output logic                o_is_store,
    output logic                o_illegal
);

    always_comb begin
        o_next_state = S_FETCH;
        o_is_store   = 1'b0;
        o_illegal    = 1'b0;
        case (opcode)
            OPCODE_W'(OP_RTYPE):
                o_next_state = (funct == FUNCT_W'(FUNCT_JR)) ? S_JR : S_EXEC_R;
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
            OPCODE_W'(OP_ORI),  OPCODE_W'(OP_SLTI):
                o_next_state = S_EXEC_I;
            OPCODE_W'(OP_LW):
                o_next_state = S_MEM_ADDR;
            OPCODE_W'(OP_SW): begin
                o_next_state = S_MEM_ADDR;
                o_is_store   = 1'b1;
            end
            OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE):
                o_next_state = S_BRANCH;
            OPCODE_W'(OP_J):
                o_next_state = S_JUMP;
            default:
                o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multi-cycle MIPS controller sequencing fetch..writeback per instruction.
// Latency 2-5 cycles per instruction; FETCH/MEM_RD/MEM_WR stall while mem_ready is low.
// Backpressure: memory handshake only; write-enables are gated by mem_ready where it matters.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int FUNCT_W       = 6,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                branch_ne,
    output logic                instr_done,
    output logic                illegal_instr
);

    state_t r_state;
    state_t w_next;
    state_t w_dec_next;
    logic   w_dec_store;
    logic   w_dec_illegal;
    logic   w_mem_rdy;
    logic   r_is_store;

    // zero only matters to the datapath's pc_write_cond gating, not to sequencing
    logic   w_unused_zero;
    assign w_unused_zero = zero;

    assign w_mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mips_op_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_op_decode (
        .opcode       (opcode),
        .funct        (funct),
        .o_next_state (w_dec_next),
        .o_is_store   (w_dec_store),
        .o_illegal    (w_dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            // opcode is not stable past DECODE, so remember lw vs sw here
            if (r_state == S_DECODE)
                r_is_store <= w_dec_store;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = w_mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_dec_next;
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = r_is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = w_mem_rdy ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = w_mem_rdy ? S_FETCH : S_MEM_WR;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        branch_ne     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = w_mem_rdy;
                    pc_write  = w_mem_rdy;
                end
                S_DECODE: begin
                    alu_src_b     = ALUB_IMMSH;
                    illegal_instr = w_dec_illegal;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    alu_op    = ALUOP_IMM;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    i_or_d     = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = w_mem_rdy;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_ALUOUT;
                    branch_ne     = (opcode == OPCODE_W'(OP_BNE));
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_RS;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed per-cycle vector bench for mips_multicycle_ctrl (handshake on and off).
module tb_mips_multicycle_ctrl;

    function automatic logic [18:0] mk(
        input logic pcw, pcwc, irw, iord, mr, mw, m2r, rw, rd, asa,
        input logic [1:0] pcs, asb, aop,
        input logic bne, done, ill);
        return {pcw, pcwc, irw, iord, mr, mw, m2r, rw, rd, asa, pcs, asb, aop, bne, done, ill};
    endfunction

    localparam logic [18:0] E_RST = 19'd0;
    localparam logic [18:0] E_F1  = mk(1,0,1,0,1,0,0,0,0,0, 2'd0,2'd1,2'd0, 0,0,0);
    localparam logic [18:0] E_F0  = mk(0,0,0,0,1,0,0,0,0,0, 2'd0,2'd1,2'd0, 0,0,0);
    localparam logic [18:0] E_DEC = mk(0,0,0,0,0,0,0,0,0,0, 2'd0,2'd3,2'd0, 0,0,0);
    localparam logic [18:0] E_ILL = mk(0,0,0,0,0,0,0,0,0,0, 2'd0,2'd3,2'd0, 0,0,1);
    localparam logic [18:0] E_EXR = mk(0,0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd2, 0,0,0);
    localparam logic [18:0] E_EXI = mk(0,0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd3, 0,0,0);
    localparam logic [18:0] E_MA  = mk(0,0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd0, 0,0,0);
    localparam logic [18:0] E_MR  = mk(0,0,0,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0);
    localparam logic [18:0] E_MW0 = mk(0,0,0,1,0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0);
    localparam logic [18:0] E_MW1 = mk(0,0,0,1,0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,1,0);
    localparam logic [18:0] E_WBR = mk(0,0,0,0,0,0,0,1,1,0, 2'd0,2'd0,2'd0, 0,1,0);
    localparam logic [18:0] E_WBI = mk(0,0,0,0,0,0,0,1,0,0, 2'd0,2'd0,2'd0, 0,1,0);
    localparam logic [18:0] E_WBM = mk(0,0,0,0,0,0,1,1,0,0, 2'd0,2'd0,2'd0, 0,1,0);
    localparam logic [18:0] E_BEQ = mk(0,1,0,0,0,0,0,0,0,1, 2'd1,2'd0,2'd1, 0,1,0);
    localparam logic [18:0] E_BNE = mk(0,1,0,0,0,0,0,0,0,1, 2'd1,2'd0,2'd1, 1,1,0);
    localparam logic [18:0] E_J   = mk(1,0,0,0,0,0,0,0,0,0, 2'd2,2'd0,2'd0, 0,1,0);
    localparam logic [18:0] E_JR  = mk(1,0,0,0,0,0,0,0,0,0, 2'd3,2'd0,2'd0, 0,1,0);

    localparam logic [5:0] XX = 6'h3F;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic mem_to_reg, reg_write, reg_dst, alu_src_a, branch_ne, instr_done, illegal_instr;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic pc_write_b, pc_write_cond_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b;
    logic mem_to_reg_b, reg_write_b, reg_dst_b, alu_src_a_b, branch_ne_b, instr_done_b, illegal_instr_b;
    logic [1:0] pc_src_b, alu_src_b_b, alu_op_b;

    logic [18:0] act, act_b;
    assign act   = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                    reg_write, reg_dst, alu_src_a, pc_src, alu_src_b, alu_op, branch_ne,
                    instr_done, illegal_instr};
    assign act_b = {pc_write_b, pc_write_cond_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b,
                    mem_to_reg_b, reg_write_b, reg_dst_b, alu_src_a_b, pc_src_b, alu_src_b_b,
                    alu_op_b, branch_ne_b, instr_done_b, illegal_instr_b};

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OPCODE_W(6), .FUNCT_W(6), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .branch_ne(branch_ne), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    mips_multicycle_ctrl #(.OPCODE_W(6), .FUNCT_W(6), .MEM_HANDSHAKE(1'b0)) dut_nohs (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
        .ir_write(ir_write_b), .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
        .alu_src_a(alu_src_a_b), .pc_src(pc_src_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .branch_ne(branch_ne_b), .instr_done(instr_done_b), .illegal_instr(illegal_instr_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic add(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [18:0] e);
        vec_t v;
        v.name = nm; v.rst_n = r; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [18:0] got, input logic [18:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b want %b", nm, got, want);
    endtask

    // drive on the falling edge, compare 1ns later, state advances on the next rising edge
    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        @(negedge clk);
        reset_n = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    initial begin
        add("rst0",        0, XX,    XX,    0, 1, E_RST);
        add("rst1",        0, 6'h00, 6'h00, 1, 1, E_RST);
        // R-type add
        add("add_fetch",   1, XX,    XX,    0, 1, E_F1);
        add("add_dec",     1, 6'h00, 6'h20, 0, 1, E_DEC);
        add("add_exec",    1, XX,    XX,    1, 1, E_EXR);
        add("add_wb",      1, XX,    XX,    0, 1, E_WBR);
        // lw with 3 wait cycles in MEM_RD
        add("lw_fetch",    1, XX,    XX,    0, 1, E_F1);
        add("lw_dec",      1, 6'h23, XX,    0, 1, E_DEC);
        add("lw_addr",     1, 6'h2B, XX,    0, 1, E_MA);
        add("lw_rd_w1",    1, XX,    XX,    0, 0, E_MR);
        add("lw_rd_w2",    1, XX,    XX,    0, 0, E_MR);
        add("lw_rd_w3",    1, XX,    XX,    0, 0, E_MR);
        add("lw_rd",       1, XX,    XX,    0, 1, E_MR);
        add("lw_wb",       1, XX,    XX,    0, 1, E_WBM);
        // beq / bne with zero=1
        add("beq_fetch",   1, XX,    XX,    1, 1, E_F1);
        add("beq_dec",     1, 6'h04, XX,    1, 1, E_DEC);
        add("beq_br",      1, 6'h04, XX,    1, 1, E_BEQ);
        add("bne_fetch",   1, XX,    XX,    1, 1, E_F1);
        add("bne_dec",     1, 6'h05, XX,    1, 1, E_DEC);
        add("bne_br",      1, 6'h05, XX,    1, 1, E_BNE);
        // jr and j
        add("jr_fetch",    1, XX,    XX,    0, 1, E_F1);
        add("jr_dec",      1, 6'h00, 6'h08, 0, 1, E_DEC);
        add("jr_exec",     1, XX,    XX,    0, 1, E_JR);
        add("j_fetch",     1, XX,    XX,    0, 1, E_F1);
        add("j_dec",       1, 6'h02, XX,    0, 1, E_DEC);
        add("j_exec",      1, XX,    XX,    0, 1, E_J);
        // ori, with two fetch stalls first
        add("ori_fwait1",  1, XX,    XX,    0, 0, E_F0);
        add("ori_fwait2",  1, XX,    XX,    0, 0, E_F0);
        add("ori_fetch",   1, XX,    XX,    0, 1, E_F1);
        add("ori_dec",     1, 6'h0D, XX,    0, 1, E_DEC);
        add("ori_exec",    1, XX,    XX,    0, 1, E_EXI);
        add("ori_wb",      1, XX,    XX,    0, 1, E_WBI);
        // slti
        add("slti_fetch",  1, XX,    XX,    0, 1, E_F1);
        add("slti_dec",    1, 6'h0A, XX,    0, 1, E_DEC);
        add("slti_exec",   1, XX,    XX,    0, 1, E_EXI);
        add("slti_wb",     1, XX,    XX,    0, 1, E_WBI);
        // illegal opcode
        add("ill_fetch",   1, XX,    XX,    0, 1, E_F1);
        add("ill_dec",     1, 6'h3F, XX,    0, 1, E_ILL);
        // sw with one wait cycle
        add("sw_fetch",    1, XX,    XX,    0, 1, E_F1);
        add("sw_dec",      1, 6'h2B, XX,    0, 1, E_DEC);
        add("sw_addr",     1, 6'h23, XX,    0, 1, E_MA);
        add("sw_wr_w",     1, XX,    XX,    0, 0, E_MW0);
        add("sw_wr",       1, XX,    XX,    0, 1, E_MW1);
        // sw abandoned by reset while waiting in MEM_WR
        add("swr_fetch",   1, XX,    XX,    0, 1, E_F1);
        add("swr_dec",     1, 6'h2B, XX,    0, 1, E_DEC);
        add("swr_addr",    1, XX,    XX,    0, 1, E_MA);
        add("swr_wr_w",    1, XX,    XX,    0, 0, E_MW0);
        add("swr_rst",     0, XX,    XX,    0, 0, E_RST);
        add("swr_refetch", 1, XX,    XX,    0, 1, E_F1);
        add("addi_dec",    1, 6'h08, XX,    0, 1, E_DEC);
        add("addi_exec",   1, XX,    XX,    0, 1, E_EXI);
        add("addi_wb",     1, XX,    XX,    0, 1, E_WBI);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].rdy);
            check(vecs[i].name, act, vecs[i].exp);
            n_checks++;
            if (!(instr_done && illegal_instr)) n_pass++;
            else $display("FAIL done_and_illegal at %s: got 1 want 0", vecs[i].name);
        end

        // handshake disabled: sw finishes in 4 cycles with mem_ready stuck low
        drive(0, XX, XX, 0, 0);
        check("nohs_rst", act_b, E_RST);
        drive(1, XX, XX, 0, 0);
        check("nohs_fetch", act_b, E_F1);
        check("hs_fetch_stall", act, E_F0);
        drive(1, 6'h2B, XX, 0, 0);
        check("nohs_dec", act_b, E_DEC);
        drive(1, XX, XX, 0, 0);
        check("nohs_addr", act_b, E_MA);
        drive(1, XX, XX, 0, 0);
        check("nohs_wr", act_b, E_MW1);
        drive(1, XX, XX, 0, 0);
        check("nohs_next_fetch", act_b, E_F1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Parametrised multi-cycle control unit for the MIPS datapath. It replaces single-signal funct decoding with a Moore state machine that sequences fetch, decode, execute, memory and writeback for R-type, immediate, load/store, branch and jump instructions, including `jr` (R-type, funct 8). It sits between the instruction register and the datapath muxes, register file, ALU and unified memory. It stalls on a memory ready handshake.

## Interface
- `OPCODE_W`, default 6: opcode field width.
- `FUNCT_W`, default 6: funct field width.
- `MEM_HANDSHAKE`, default 1: 1 means memory states wait for `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.
- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `opcode`, input, `OPCODE_W`: from the instruction register.
- `funct`, input, `FUNCT_W`: from the instruction register.
- `zero`, input, 1: ALU zero flag, valid in the BRANCH state.
- `mem_ready`, input, 1: memory access completes this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a`, output, 1 each: datapath controls.
- `pc_src`, output, 2: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = register rs.
- `alu_src_b`, output, 2: 0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate shifted left by 2.
- `alu_op`, output, 2: 0 = add, 1 = sub, 2 = funct, 3 = immediate-op (uses the opcode).
- `branch_ne`, output, 1: inverts the `zero` sense for `bne`.
- `instr_done`, output, 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_instr`, output, 1: one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- Supported opcodes:
  - R-type 0x00
  - lw 0x23, sw 0x2B
  - beq 0x04, bne 0x05
  - addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A
  - j 0x02
- R-type with funct 0x08 is `jr`.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR.
- Transitions:
  - FETCH → DECODE on `mem_ready`; otherwise hold in FETCH.
  - DECODE → EXEC_R (R-type, funct ≠ 8), JR (R-type, funct = 8), EXEC_I (imm ops), MEM_ADDR (lw/sw), BRANCH (beq/bne), JUMP (j). Any other opcode → FETCH, with `illegal_instr`.
  - EXEC_R → WB_R, then FETCH. EXEC_I → WB_I, then FETCH.
  - MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD → WB_MEM on `mem_ready`, then FETCH. MEM_WR → FETCH on `mem_ready`. Both hold while `mem_ready` = 0.
  - BRANCH, JUMP, JR → FETCH.
- Outputs are a pure function of the current state, plus `mem_ready` for the write-enables in FETCH and MEM_WR. Every output not listed for a state is 0.
  - FETCH: `mem_read`=1, `alu_src_b`=1. `ir_write` and `pc_write` assert only when `mem_ready`=1.
  - DECODE: `alu_src_b`=3.
  - EXEC_R: `alu_src_a`=1, `alu_op`=2.
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2.
  - MEM_RD: `mem_read`=1, `i_or_d`=1.
  - MEM_WR: `i_or_d`=1, `mem_write`=1 (held while waiting).
  - WB_R: `reg_write`=1, `reg_dst`=1.
  - WB_I: `reg_write`=1.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=1, `pc_write_cond`=1, `pc_src`=1, `branch_ne`=(opcode==0x05).
  - JUMP: `pc_write`=1, `pc_src`=2.
  - JR: `pc_write`=1, `pc_src`=3.
- `instr_done`=1 in:
  - WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR;
  - MEM_WR when `mem_ready`=1.
- `opcode` and `funct` are sampled only in DECODE and BRANCH. Their values in other states are don't-care.

## Timing
- Reset: while `reset_n`=0 at a rising edge, the state becomes FETCH. All outputs are forced to 0 combinationally while `reset_n`=0.
- First fetch: FETCH begins on the first cycle after `reset_n` returns high.
- Latencies with `mem_ready` held at 1, in cycles including FETCH:
  - R-type 4, imm 4, lw 5, sw 4, beq/bne 3, j 3, jr 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. No write-enable asserts during those wait cycles, except that `mem_write` stays asserted in MEM_WR.
- Reset asserted mid-instruction abandons the instruction. No `instr_done` is produced for it.
- `illegal_instr` and `instr_done` are never asserted in the same cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode and funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, FUNCT_JR);
  - the `pc_src`, `alu_src_b` and `alu_op` encodings.
- Optional sub-module `mips_op_decode`: a combinational map from opcode/funct to the next state out of DECODE. It is shared with a future pipelined controller.

## Test plan
- Reset, then an R-type add (opcode 0, funct 0x20) with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_R. `reg_write`=`reg_dst`=1 in cycle 4, then `instr_done` pulses.
- lw with `mem_ready` low for 3 cycles in MEM_RD → 8 cycles total. `reg_write`=1 only in WB_MEM. `ir_write`=0 throughout the wait.
- beq with `zero`=1, then bne with `zero`=1 → `pc_write_cond`=1 and `pc_src`=1 in both. `branch_ne`=0 for beq, 1 for bne.
- jr (opcode 0, funct 8) → 3 cycles, `pc_write`=1 and `pc_src`=3 in cycle 3. Same for j, with `pc_src`=2.
- opcode 0x3F → `illegal_instr` pulse in DECODE, back to FETCH. No `reg_write`/`mem_write`/`pc_write` beyond fetch.
- `reset_n` low during MEM_WR with `mem_ready`=0 → all outputs 0 that cycle, FETCH next, no `instr_done`. `MEM_HANDSHAKE`=0 → sw completes in 4 cycles regardless of `mem_ready`.
